xpb_lookup_sequencer: RTL
=========================

// Module: xpb_lookup_sequencer
// PURPOSE
//   Time-shares one registered xpb reduction-table bank across NUM_SEG
//   segments of a modular-square overflow word. Issues one lookup per cycle,
//   (table id = segment index, select = that segment's DIG_W-bit digit), then
//   accumulates the returned WIDTH-bit constants into one non-wrapping sum.
//   Sits between the squarer's overflow split and the final reduction adder.
// PARAMETERS
//   WIDTH       1024  width of one xpb table entry
//   DIG_W       5     digit width per segment (table select width)
//   NUM_SEG     16    segments/tables per operation (>=2)
//   LOOKUP_LAT  1     cycles from xpb_sel/xpb_tbl to xpb_data (0..4; 0 = combinational ROM)
//   ACC_EXT     5     accumulator extension bits; must be >= clog2(NUM_SEG)+1
// PORTS
//   clk            in   1                   clock
//   reset          in   1                   synchronous, active-high reset
//   start          in   1                   begin operation; accepted only in IDLE
//   digits_in      in   NUM_SEG*DIG_W       segment digits; seg i = bits [i*DIG_W +: DIG_W]; sampled at accepted start
//   busy           out  1                   high in ISSUE, DRAIN and DONE
//   xpb_req_valid  out  1                   lookup issued this cycle
//   xpb_tbl        out  clog2(NUM_SEG)      table (segment) index of the lookup
//   xpb_sel        out  DIG_W               digit driving the table select
//   xpb_data       in   WIDTH               table output, LOOKUP_LAT cycles after the issue
//   result         out  WIDTH+ACC_EXT       sum of all NUM_SEG returned entries; holds until the next done
//   done           out  1                   one-cycle pulse; result is valid from this cycle
// BEHAVIOUR
//   Reset: state=IDLE; busy, done, xpb_req_valid=0; xpb_tbl, xpb_sel, result, accumulator=0;
//     return-valid pipe flushed.
//   FSM: IDLE -(start)-> ISSUE -(last seg issued)-> DRAIN -(last return added)-> DONE -> IDLE.
//   Accepted start at edge T0: latch digits_in; clear accumulator; seg counter=0.
//   ISSUE, cycles T0+1 .. T0+NUM_SEG: xpb_req_valid=1; xpb_tbl=k; xpb_sel=digit k (k=0..NUM_SEG-1).
//     xpb_req_valid is 0 in every other state; xpb_tbl and xpb_sel are then don't-care.
//   Returns: a LOOKUP_LAT-deep valid shift register tags xpb_data.
//     Entry k is added at the end of cycle T0+1+k+LOOKUP_LAT.
//     The add is zero-extended to WIDTH+ACC_EXT bits; there is no modular wrap and no carry is lost.
//   DRAIN lasts LOOKUP_LAT cycles (0 when LOOKUP_LAT=0: ISSUE goes straight to DONE).
//   DONE: single cycle T0+NUM_SEG+LOOKUP_LAT+1. done=1; result=final accumulator in the same cycle.
//   Latency start->done = NUM_SEG+LOOKUP_LAT+1 cycles. Minimum start-to-start spacing is this plus 1.
//   A zero digit still issues a lookup. The table returns 0, so timing stays fixed.
//   start in ISSUE, DRAIN or DONE is ignored; it is not queued. digits_in changes after T0 are ignored.
//   reset mid-operation: immediate return to the reset state. Pending returns are discarded;
//     done does not pulse; result is cleared to 0.
//   result changes only on a done cycle or on reset.
// TESTING (bench model ROM with LOOKUP_LAT=1 unless noted; defaults otherwise)
//   1 All digits 0, model returns 0 -> done exactly 18 cycles after start; result=0;
//     xpb_req_valid high for exactly 16 cycles with xpb_tbl 0..15.
//   2 Model returns {tbl,sel} zero-extended; digits i=i+1 -> result = sum_{i=0..15}((i<<5)|(i+1)) = 0x0F88.
//   3 Model returns all-ones WIDTH for sel!=0; all digits 31 -> result = 16*(2^1024-1) (carry into ACC_EXT bits).
//   4 start again at done+1 with new digits; start also pulsed mid-ISSUE
//     -> mid-ISSUE start ignored; second op correct; first result held until second done.
//   5 reset asserted at cycle 8 of ISSUE -> no done; result=0; a new start then completes normally.
//   6 Repeat scenarios 1-2 with LOOKUP_LAT=0 and LOOKUP_LAT=3 -> done after 17 and 20 cycles; same result values.

Source files
------------

// File: rtl/xpb_lookup_sequencer.sv
// Sequences NUM_SEG lookups through one shared xpb reduction-table bank and
// accumulates the returned constants into a single non-wrapping sum.
module xpb_lookup_sequencer #(
  parameter int WIDTH      = 1024,
  parameter int DIG_W      = 5,
  parameter int NUM_SEG    = 16,
  parameter int LOOKUP_LAT = 1,
  parameter int ACC_EXT    = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [NUM_SEG*DIG_W-1:0]   digits_in,
  output logic                       busy,
  output logic                       xpb_req_valid,
  output logic [$clog2(NUM_SEG)-1:0] xpb_tbl,
  output logic [DIG_W-1:0]           xpb_sel,
  input  logic [WIDTH-1:0]           xpb_data,
  output logic [WIDTH+ACC_EXT-1:0]   result,
  output logic                       done
);

  localparam int SEG_W = $clog2(NUM_SEG);
  localparam int ACC_W = WIDTH + ACC_EXT;
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                     state_q, state_d;
  logic [SEG_W-1:0]           seg_q, seg_d;
  logic [CNT_W-1:0]           drain_q, drain_d;
  logic [NUM_SEG*DIG_W-1:0]   digits_q, digits_d;
  logic [ACC_W-1:0]           acc_q, acc_d;
  logic [ACC_W-1:0]           result_q, result_d;
  logic                       ret_valid;
  logic [DIG_W-1:0]           dig_arr [NUM_SEG];

  for (genvar gi = 0; gi < NUM_SEG; gi++) begin : g_dig
    assign dig_arr[gi] = digits_q[gi*DIG_W +: DIG_W];
  end

  // Valid tag travels alongside the table's read latency so each return is
  // added exactly once, in the cycle its data appears.
  if (LOOKUP_LAT == 0) begin : g_ret_comb
    assign ret_valid = xpb_req_valid;
  end else begin : g_ret_pipe
    logic [LOOKUP_LAT-1:0] vld_q;
    always_ff @(posedge clk) begin
      if (reset) begin
        vld_q <= '0;
      end else begin
        vld_q[0] <= xpb_req_valid;
        for (int i = 1; i < LOOKUP_LAT; i++) begin
          vld_q[i] <= vld_q[i-1];
        end
      end
    end
    assign ret_valid = vld_q[LOOKUP_LAT-1];
  end

  always_comb begin
    state_d       = state_q;
    seg_d         = seg_q;
    drain_d       = drain_q;
    digits_d      = digits_q;
    acc_d         = acc_q;
    result_d      = result_q;
    xpb_req_valid = 1'b0;

    if (ret_valid) begin
      acc_d = acc_q + ACC_W'(xpb_data);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_ISSUE;
          seg_d    = '0;
          digits_d = digits_in;
          acc_d    = '0;
        end
      end
      S_ISSUE: begin
        xpb_req_valid = 1'b1;
        seg_d         = seg_q + 1'b1;
        if (seg_q == SEG_W'(NUM_SEG - 1)) begin
          if (LOOKUP_LAT == 0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_DRAIN;
            drain_d = CNT_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (drain_q == CNT_W'(LOOKUP_LAT)) begin
          state_d = S_DONE;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Capture on entry to DONE so result is already final during the done pulse.
    if (state_q != S_DONE && state_d == S_DONE) begin
      result_d = acc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      seg_q    <= '0;
      drain_q  <= '0;
      digits_q <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      seg_q    <= seg_d;
      drain_q  <= drain_d;
      digits_q <= digits_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign xpb_tbl = seg_q;
  assign xpb_sel = dig_arr[seg_q];
  assign result  = result_q;

endmodule
